// File: rtl/i2c_txn_sequencer.sv
// Transaction sequencer ahead of the I2C byte engine: expands a page-write or
// random-read command into engine byte steps, paces the engine clock, times out missing ACKs.
module i2c_txn_sequencer #(
    parameter int PAGE_SIZE     = 16,
    parameter int DIV           = 1000,
    parameter int TIMEOUT_TICKS = 64,
    parameter int WR_DELAY      = 120000
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       cmd_start,
    input  logic       cmd_op,
    input  logic [2:0] cmd_dev,
    input  logic [7:0] cmd_addr,
    input  logic [4:0] cmd_len,
    input  logic       buf_wr_en,
    input  logic [3:0] buf_addr,
    input  logic [7:0] buf_wdata,
    output logic [7:0] buf_rdata,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       eng_clock,
    output logic       eng_nreset,
    output logic [7:0] eng_write_byte,
    output logic       eng_read_mode,
    output logic       eng_do_start,
    output logic       eng_expect_ack,
    output logic       eng_do_stop,
    input  logic [7:0] eng_read_byte,
    input  logic       eng_finished
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int WW = (WR_DELAY > 1) ? $clog2(WR_DELAY) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_TICKS);
    localparam logic [TW-1:0] MIN_TOGS  = TW'(2);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WR_DELAY - 1);
    localparam logic [4:0]    PAGE_LEN  = 5'(PAGE_SIZE);
    localparam logic [7:0]    PAGE_MASK = 8'(PAGE_SIZE - 1);
    localparam logic [8:0]    PAGE_END  = 9'(PAGE_SIZE);
    localparam logic [3:0]    IDX_MASK  = 4'(PAGE_SIZE - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        CHECK      = 4'd1,
        STEP_SETUP = 4'd2,
        STEP_RESET = 4'd3,
        STEP_RUN   = 4'd4,
        STEP_DONE  = 4'd5,
        WR_WAIT    = 4'd6,
        FINISH     = 4'd7,
        ERROR      = 4'd8
    } state_t;

    state_t        state_r, state_n;
    logic          op_r, op_n;
    logic [2:0]    dev_r, dev_n;
    logic [7:0]    addr_r, addr_n;
    logic [4:0]    len_r, len_n, idx_r, idx_n;
    logic [1:0]    phase_r, phase_n;
    logic [DW-1:0] div_r, div_n;
    logic [TW-1:0] tog_r, tog_n, tog_inc_s;
    logic [WW-1:0] wait_r, wait_n;
    logic          busy_r, busy_n, done_r, done_n, error_r, error_n;
    logic          eclk_r, eclk_n, enrst_r, enrst_n;
    logic [7:0]    ewb_r, ewb_n;
    logic          erm_r, erm_n, est_r, est_n, eack_r, eack_n, esp_r, esp_n;
    logic [7:0]    buf_r [PAGE_SIZE];
    logic          buf_we_s;
    logic [3:0]    buf_wa_s;
    logic [7:0]    buf_wd_s;
    logic [7:0]    ctl_byte_s;
    logic          ctl_start_s, ctl_ack_s, ctl_stop_s, ctl_read_s;
    logic          last_s, fail_s;
    logic [7:0]    devsel_w_s, devsel_r_s;

    assign buf_rdata      = buf_r[buf_addr & IDX_MASK];
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign eng_clock      = eclk_r;
    assign eng_nreset     = enrst_r;
    assign eng_write_byte = ewb_r;
    assign eng_read_mode  = erm_r;
    assign eng_do_start   = est_r;
    assign eng_expect_ack = eack_r;
    assign eng_do_stop    = esp_r;

    assign devsel_w_s = {4'b1010, dev_r, 1'b0};
    assign devsel_r_s = {4'b1010, dev_r, 1'b1};
    assign last_s     = (idx_r == (len_r - 5'd1));
    assign tog_inc_s  = tog_r + TW'(1);
    assign fail_s     = (len_r == 5'd0) || (len_r > PAGE_LEN) ||
                        (!op_r && (({1'b0, addr_r & PAGE_MASK} + {4'b0000, len_r}) > PAGE_END));

    // Engine controls for the current step; reads use one random read per byte
    always_comb begin
        ctl_byte_s  = 8'h00;
        ctl_start_s = 1'b0;
        ctl_ack_s   = 1'b1;
        ctl_stop_s  = 1'b0;
        ctl_read_s  = 1'b0;
        if (!op_r) begin
            case (phase_r)
                2'd0: begin
                    ctl_byte_s  = devsel_w_s;
                    ctl_start_s = 1'b1;
                end
                2'd1:    ctl_byte_s = addr_r;
                default: begin
                    ctl_byte_s = buf_r[idx_r[3:0] & IDX_MASK];
                    ctl_stop_s = last_s;
                end
            endcase
        end else begin
            case (phase_r)
                2'd0: begin
                    ctl_byte_s  = devsel_w_s;
                    ctl_start_s = 1'b1;
                end
                2'd1: ctl_byte_s = addr_r + {3'b000, idx_r};
                2'd2: begin
                    ctl_byte_s  = devsel_r_s;
                    ctl_start_s = 1'b1;
                end
                default: begin
                    ctl_ack_s  = 1'b0;
                    ctl_stop_s = 1'b1;
                    ctl_read_s = 1'b1;
                end
            endcase
        end
    end

    // Next-state and next-output logic for the command sequencer
    always_comb begin
        state_n  = state_r;
        op_n     = op_r;
        dev_n    = dev_r;
        addr_n   = addr_r;
        len_n    = len_r;
        idx_n    = idx_r;
        phase_n  = phase_r;
        div_n    = div_r;
        tog_n    = tog_r;
        wait_n   = wait_r;
        busy_n   = busy_r;
        done_n   = 1'b0;
        error_n  = error_r;
        eclk_n   = eclk_r;
        enrst_n  = enrst_r;
        ewb_n    = ewb_r;
        erm_n    = erm_r;
        est_n    = est_r;
        eack_n   = eack_r;
        esp_n    = esp_r;
        buf_we_s = 1'b0;
        buf_wa_s = buf_addr;
        buf_wd_s = buf_wdata;
        case (state_r)
            IDLE: begin
                buf_we_s = buf_wr_en;
                if (cmd_start) begin
                    op_n    = cmd_op;
                    dev_n   = cmd_dev;
                    addr_n  = cmd_addr;
                    len_n   = cmd_len;
                    error_n = 1'b0;
                    busy_n  = 1'b1;
                    state_n = CHECK;
                end else begin
                    state_n = IDLE;
                end
            end
            CHECK: begin
                if (fail_s) begin
                    error_n = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    idx_n   = 5'd0;
                    phase_n = 2'd0;
                    state_n = STEP_SETUP;
                end
            end
            STEP_SETUP: begin
                ewb_n   = ctl_byte_s;
                est_n   = ctl_start_s;
                eack_n  = ctl_ack_s;
                esp_n   = ctl_stop_s;
                erm_n   = ctl_read_s;
                enrst_n = 1'b0;
                eclk_n  = 1'b0;
                state_n = STEP_RESET;
            end
            STEP_RESET: begin
                enrst_n = 1'b1;
                div_n   = '0;
                tog_n   = '0;
                state_n = STEP_RUN;
            end
            STEP_RUN: begin
                if (div_r == DIV_LAST) begin
                    div_n  = '0;
                    eclk_n = ~eclk_r;
                    tog_n  = tog_inc_s;
                    // Completion wins over timeout when both land on the same toggle
                    if (eng_finished && (tog_inc_s >= MIN_TOGS)) begin
                        buf_we_s = erm_r;
                        buf_wa_s = idx_r[3:0];
                        buf_wd_s = eng_read_byte;
                        state_n  = STEP_DONE;
                    end else if (tog_inc_s >= TO_LIMIT) begin
                        state_n = ERROR;
                    end else begin
                        state_n = STEP_RUN;
                    end
                end else begin
                    div_n = div_r + DW'(1);
                end
            end
            STEP_DONE: begin
                enrst_n = 1'b0;
                state_n = STEP_SETUP;
                if (!op_r) begin
                    if (phase_r == 2'd2) begin
                        if (last_s) begin
                            wait_n  = '0;
                            state_n = WR_WAIT;
                        end else begin
                            idx_n = idx_r + 5'd1;
                        end
                    end else begin
                        phase_n = phase_r + 2'd1;
                    end
                end else begin
                    if (phase_r == 2'd3) begin
                        if (last_s) begin
                            state_n = FINISH;
                        end else begin
                            phase_n = 2'd0;
                            idx_n   = idx_r + 5'd1;
                        end
                    end else begin
                        phase_n = phase_r + 2'd1;
                    end
                end
            end
            WR_WAIT: begin
                if (wait_r == WAIT_LAST) begin
                    state_n = FINISH;
                end else begin
                    wait_n = wait_r + WW'(1);
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            ERROR: begin
                enrst_n = 1'b0;
                eclk_n  = 1'b0;
                error_n = 1'b1;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                enrst_n = 1'b0;
                eclk_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State, command and engine-output registers
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r <= IDLE;
            op_r    <= 1'b0;
            dev_r   <= 3'd0;
            addr_r  <= 8'h00;
            len_r   <= 5'd0;
            idx_r   <= 5'd0;
            phase_r <= 2'd0;
            div_r   <= '0;
            tog_r   <= '0;
            wait_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            eclk_r  <= 1'b0;
            enrst_r <= 1'b0;
            ewb_r   <= 8'h00;
            erm_r   <= 1'b0;
            est_r   <= 1'b0;
            eack_r  <= 1'b0;
            esp_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            op_r    <= op_n;
            dev_r   <= dev_n;
            addr_r  <= addr_n;
            len_r   <= len_n;
            idx_r   <= idx_n;
            phase_r <= phase_n;
            div_r   <= div_n;
            tog_r   <= tog_n;
            wait_r  <= wait_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            error_r <= error_n;
            eclk_r  <= eclk_n;
            enrst_r <= enrst_n;
            ewb_r   <= ewb_n;
            erm_r   <= erm_n;
            est_r   <= est_n;
            eack_r  <= eack_n;
            esp_r   <= esp_n;
        end
    end

    // Data buffer: host writes while idle, captured read bytes during a read
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < PAGE_SIZE; i++) begin
                buf_r[i] <= 8'h00;
            end
        end else if (buf_we_s) begin
            buf_r[buf_wa_s & IDX_MASK] <= buf_wd_s;
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench: behavioural engine + EEPROM model, scoreboard of expected engine steps,
// table of commands plus hand-written timeout, busy-ignore and mid-step reset sequences.
module tb_i2c_txn_sequencer;
    localparam int WRD = 10;

    logic       clock = 1'b0, nreset = 1'b0;
    logic       cmd_start = 1'b0, cmd_op = 1'b0;
    logic [2:0] cmd_dev = 3'd0;
    logic [7:0] cmd_addr = 8'h00;
    logic [4:0] cmd_len = 5'd0;
    logic       buf_wr_en = 1'b0;
    logic [3:0] buf_addr = 4'd0;
    logic [7:0] buf_wdata = 8'h00, buf_rdata;
    logic       busy, done, error, eng_clock, eng_nreset;
    logic [7:0] eng_write_byte;
    logic       eng_read_mode, eng_do_start, eng_expect_ack, eng_do_stop;
    logic [7:0] eng_read_byte = 8'h00;
    logic       eng_finished = 1'b0;

    i2c_txn_sequencer #(.PAGE_SIZE(16), .DIV(2), .TIMEOUT_TICKS(8), .WR_DELAY(WRD)) dut (
        .clock(clock), .nreset(nreset), .cmd_start(cmd_start), .cmd_op(cmd_op),
        .cmd_dev(cmd_dev), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .buf_wr_en(buf_wr_en),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata), .busy(busy),
        .done(done), .error(error), .eng_clock(eng_clock), .eng_nreset(eng_nreset),
        .eng_write_byte(eng_write_byte), .eng_read_mode(eng_read_mode),
        .eng_do_start(eng_do_start), .eng_expect_ack(eng_expect_ack),
        .eng_do_stop(eng_do_stop), .eng_read_byte(eng_read_byte), .eng_finished(eng_finished));

    always #5 clock = ~clock;

    typedef struct packed {logic [7:0] b; logic s; logic a; logic p; logic r;} step_t;
    typedef struct {logic op; logic [2:0] dev; logic [7:0] addr; logic [4:0] len; logic err; int steps;} vec_t;

    step_t      exp_q[$];
    vec_t       vecs[8];
    int         checks = 0, errors = 0;
    logic [7:0] mem [256];
    logic [7:0] tb_buf [16];
    int         nsteps = 0, tog = 0, ncyc = 0, fall_cyc = 0;
    logic       prev_nr = 1'b0, prev_ck = 1'b0, ack_ok = 1'b1, nack_devsel = 1'b0, addr_phase = 1'b0;
    logic [7:0] ptr = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Engine + EEPROM model; each step start is checked against the scoreboard
    always @(negedge clock) begin
        step_t e;
        ncyc++;
        if (eng_nreset && !prev_nr) begin
            tog = 0;
            eng_finished = 1'b0;
            nsteps++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step actual=%0h expected=none", eng_write_byte);
            end else begin
                e = exp_q.pop_front();
                chk("step_flags", {eng_do_start, eng_expect_ack, eng_do_stop, eng_read_mode}, {e.s, e.a, e.p, e.r});
                if (!e.r) chk("step_byte", eng_write_byte, e.b);
            end
            ack_ok = !(nack_devsel && eng_do_start);
            if (eng_do_start) begin
                addr_phase = !eng_write_byte[0];
            end else if (addr_phase) begin
                ptr = eng_write_byte;
                addr_phase = 1'b0;
            end else if (eng_read_mode) begin
                eng_read_byte = mem[ptr];
                ptr = ptr + 8'd1;
            end else begin
                mem[ptr] = eng_write_byte;
                ptr = {ptr[7:4], ptr[3:0] + 4'd1};
            end
        end else if (eng_nreset) begin
            if (eng_clock != prev_ck) begin
                tog++;
                if (tog >= 2 && ack_ok) eng_finished = 1'b1;
            end
        end else begin
            eng_finished = 1'b0;
            if (prev_nr) fall_cyc = ncyc;
        end
        prev_nr = eng_nreset;
        prev_ck = eng_clock;
    end

    task automatic push_cmd(input vec_t v);
        step_t e;
        logic [7:0] dw, dr, a;
        dw = {4'b1010, v.dev, 1'b0};
        dr = {4'b1010, v.dev, 1'b1};
        if (!v.op) begin
            e = {dw, 4'b1100}; exp_q.push_back(e);
            e = {v.addr, 4'b0100}; exp_q.push_back(e);
            for (int i = 0; i < int'(v.len); i++) begin
                e = {tb_buf[i], 1'b0, 1'b1, 1'(i == int'(v.len) - 1), 1'b0};
                exp_q.push_back(e);
            end
        end else begin
            for (int i = 0; i < int'(v.len); i++) begin
                a = v.addr + 8'(i);
                e = {dw, 4'b1100}; exp_q.push_back(e);
                e = {a, 4'b0100}; exp_q.push_back(e);
                e = {dr, 4'b1100}; exp_q.push_back(e);
                e = {8'h00, 4'b0011}; exp_q.push_back(e);
                tb_buf[i] = mem[a];
            end
        end
    endtask

    task automatic start_cmd(input vec_t v, input bit push_all);
        nsteps = 0;
        if (push_all && !v.err) push_cmd(v);
        cmd_op = v.op; cmd_dev = v.dev; cmd_addr = v.addr; cmd_len = v.len;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 5000) begin
            tick();
            cyc++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n;
        vec_t v;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h55;
        mem[8'hFE] = 8'h5A; mem[8'hFF] = 8'hA5; mem[8'h00] = 8'h3C;
        for (int i = 0; i < 16; i++) tb_buf[i] = 8'h00;
        vecs[0] = '{1'b0, 3'd0, 8'h04, 5'd3,  1'b0, 5};
        vecs[1] = '{1'b1, 3'd0, 8'hFE, 5'd3,  1'b0, 12};
        vecs[2] = '{1'b0, 3'd0, 8'h00, 5'd0,  1'b1, 0};
        vecs[3] = '{1'b0, 3'd0, 8'h00, 5'd17, 1'b1, 0};
        vecs[4] = '{1'b0, 3'd0, 8'h0E, 5'd3,  1'b1, 0};
        vecs[5] = '{1'b1, 3'd3, 8'h0E, 5'd3,  1'b0, 12};
        vecs[6] = '{1'b0, 3'd0, 8'h10, 5'd16, 1'b0, 18};
        vecs[7] = '{1'b1, 3'd0, 8'h00, 5'd0,  1'b1, 0};

        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_eng_nreset", eng_nreset, 1'b0);
        chk("rst_eng_ctl", {eng_clock, eng_do_start, eng_expect_ack, eng_do_stop, eng_read_mode, eng_write_byte}, 13'd0);
        chk("rst_buf", buf_rdata, 8'h00);
        nreset = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            buf_addr = 4'(i);
            buf_wdata = 8'h11 * 8'(i + 1);
            tb_buf[i] = buf_wdata;
            buf_wr_en = 1'b1;
            tick();
        end
        buf_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            buf_addr = 4'(i);
            #1;
            chk("preload", buf_rdata, tb_buf[i]);
        end

        for (int k = 0; k < 8; k++) begin
            start_cmd(vecs[k], 1'b1);
            wait_done(cyc);
            chk("error", error, vecs[k].err);
            chk("busy_at_done", busy, 1'b0);
            if (vecs[k].err) chk("err_latency", cyc, 2);
            chk("nsteps", nsteps, vecs[k].steps);
            chk("sb_empty", exp_q.size(), 0);
            if (!vecs[k].op && !vecs[k].err)
                chk("wr_delay", (ncyc - fall_cyc >= WRD) && (ncyc - fall_cyc <= WRD + 3), 1'b1);
            tick();
            chk("done_pulse", done, 1'b0);
            chk("error_sticky", error, vecs[k].err);
            if (vecs[k].op && !vecs[k].err) begin
                for (int i = 0; i < int'(vecs[k].len); i++) begin
                    buf_addr = 4'(i);
                    #1;
                    chk("read_buf", buf_rdata, tb_buf[i]);
                end
            end
        end

        // Devsel never ACKed: timeout in the first step, nothing after it
        nack_devsel = 1'b1;
        v = '{1'b0, 3'd0, 8'h00, 5'd1, 1'b1, 1};
        exp_q.push_back(step_t'({8'hA0, 4'b1100}));
        start_cmd(v, 1'b0);
        wait_done(cyc);
        chk("to_error", error, 1'b1);
        chk("to_toggles", tog, 8);
        chk("to_eng_nreset", eng_nreset, 1'b0);
        repeat (40) tick();
        chk("to_nsteps", nsteps, 1);
        chk("to_sb_empty", exp_q.size(), 0);
        chk("to_error_sticky", error, 1'b1);
        nack_devsel = 1'b0;

        // cmd_start and buf_wr_en while busy are ignored
        v = '{1'b1, 3'd0, 8'h30, 5'd2, 1'b0, 8};
        start_cmd(v, 1'b1);
        repeat (15) tick();
        cmd_op = 1'b0; cmd_addr = 8'h99; cmd_len = 5'd1; cmd_start = 1'b1;
        buf_wr_en = 1'b1; buf_addr = 4'd0; buf_wdata = 8'hEE;
        tick();
        cmd_start = 1'b0; buf_wr_en = 1'b0;
        wait_done(cyc);
        chk("busy_ign_error", error, 1'b0);
        chk("busy_ign_nsteps", nsteps, 8);
        chk("busy_ign_sb", exp_q.size(), 0);
        for (int i = 0; i < 2; i++) begin
            buf_addr = 4'(i);
            #1;
            chk("busy_ign_buf", buf_rdata, tb_buf[i]);
        end

        // Reset in the middle of a step
        v = '{1'b1, 3'd0, 8'h40, 5'd2, 1'b0, 8};
        start_cmd(v, 1'b1);
        n = 0;
        while (!eng_nreset && n < 200) begin
            tick();
            n++;
        end
        chk("step_began", eng_nreset, 1'b1);
        tick();
        #2 nreset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_flags", {done, error, eng_nreset, eng_clock}, 4'd0);
        chk("mid_rst_ctl", {eng_do_start, eng_expect_ack, eng_do_stop, eng_read_mode, eng_write_byte}, 12'd0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) tb_buf[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            buf_addr = 4'(i);
            #1;
            chk("mid_rst_buf", buf_rdata, 8'h00);
        end
        tick();
        nreset = 1'b1;
        tick();

        v = '{1'b0, 3'd0, 8'h20, 5'd1, 1'b0, 3};
        start_cmd(v, 1'b1);
        wait_done(cyc);
        chk("recover_error", error, 1'b0);
        chk("recover_nsteps", nsteps, 3);
        chk("recover_sb", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
- Transaction-level sequencer directly upstream of the I2C byte engine (start/byte/ack/stop primitive with its own clock and active-low reset).
- Turns one host command ("page write N bytes" or "read N bytes") into the ordered byte steps an M24C16-class EEPROM needs, and paces the engine clock.
- Buffers up to PAGE_SIZE data bytes and detects missing ACKs by timeout.
- Replaces the per-byte command handshaking the host otherwise performs over the microcontroller bus.

Parameters:
- PAGE_SIZE, 16: data buffer depth and EEPROM page size in bytes. Power of two, ≤16.
- DIV, 1000: clock cycles per engine-clock half period.
- TIMEOUT_TICKS, 64: engine-clock toggles allowed per byte step before error.
- WR_DELAY, 120000: clock cycles waited after a write's stop condition, for the EEPROM write cycle.

Ports:
- clock, input, 1: system clock (24 MHz).
- nreset, input, 1: asynchronous active-low reset.
- cmd_start, input, 1: single-cycle command strobe.
- cmd_op, input, 1: 0 = page write, 1 = read.
- cmd_dev, input, 3: device/block select bits placed in devsel[3:1].
- cmd_addr, input, 8: start byte address.
- cmd_len, input, 5: byte count, valid range 1..PAGE_SIZE.
- buf_wr_en, input, 1: host write strobe into the buffer.
- buf_addr, input, 4: buffer index for host write and read.
- buf_wdata, input, 8: host write data.
- buf_rdata, output, 8: buffer[buf_addr], combinational.
- busy, output, 1: command in progress.
- done, output, 1: one-cycle pulse at command end, on success or error.
- error, output, 1: sticky failure flag.
- eng_clock, output, 1: byte engine clock.
- eng_nreset, output, 1: byte engine reset.
- eng_write_byte, output, 8: byte to transmit.
- eng_read_mode, output, 1: engine receives instead of transmits.
- eng_do_start, output, 1: engine issues start condition.
- eng_expect_ack, output, 1: engine waits for slave ACK.
- eng_do_stop, output, 1: engine issues stop condition.
- eng_read_byte, input, 8: byte received by engine.
- eng_finished, input, 1: engine step complete.

Behaviour:
- Reset (async): busy=0, done=0, error=0, eng_clock=0, eng_nreset=0, all eng_* controls 0, buffer cleared to 0, state IDLE.
- Reset mid-transaction: immediate abort, no stop condition issued.
- IDLE:
  - buf_wr_en writes buffer[buf_addr].
  - cmd_start latches cmd_*, clears error, sets busy next cycle, goes to CHECK.
  - buf_wr_en is ignored while busy. cmd_start is ignored while busy.
- CHECK (1 cycle): fails if len==0, len>PAGE_SIZE, or, for writes only, addr mod PAGE_SIZE + len > PAGE_SIZE.
  - On failure: error=1, done pulse, busy=0. No engine activity; eng_nreset stays 0.
- Byte step = STEP_SETUP → STEP_RESET → STEP_RUN → STEP_DONE:
  - SETUP: drive eng_* controls, hold eng_nreset=0, eng_clock=0.
  - RESET: release eng_nreset=1 and start the toggle counter.
  - RUN: toggle eng_clock every DIV cycles.
    - After each toggle, once ≥2 toggles have occurred, eng_finished=1 ends the step.
    - If received, eng_read_byte is captured into buffer[i].
    - Toggle count reaching TIMEOUT_TICKS → ERROR.
  - DONE: eng_nreset=0, controls held, advance to the next step.
- devsel byte = {4'b1010, cmd_dev, rw}.
- Write sequence (flags listed as start/ack/stop):
  - devsel-W (1/1/0).
  - addr (0/1/0).
  - data buffer[0..len-1] (0/1/0); the last data byte uses (0/1/1).
  - Then WR_WAIT for WR_DELAY cycles, then FINISH.
- Read sequence, per byte i = 0..len-1, using a random read per byte:
  - devsel-W (1/1/0).
  - addr+i (0/1/0).
  - devsel-R (1/1/0).
  - data with read_mode=1 (0/0/1) → buffer[i].
  - Address sum is 8-bit and wraps FF→00; cmd_dev is unchanged.
- FINISH: done pulse for 1 cycle, busy=0 in the same cycle as done, return to IDLE.
- ERROR: eng_nreset=0, eng_clock=0, error=1, done pulse, busy=0.
  - Remaining steps are skipped and no stop is sent; host recovery is a new command.
- buf_rdata is valid at any time. During a read it reflects bytes already stored.

Test Plan:
- DIV=2, WR_DELAY=10, model EEPROM at dev=0. Buffer preloaded 11,22,33. Write addr=0x04 len=3 → engine sees A0(start), 04, 11, 22, 33(stop); done once; error=0; busy drops after WR_DELAY.
- Read addr=0xFE len=3, model data FE=5A, FF=A5, 00=3C → 12 steps; devsel-R byte = A1; buffer[0..2] = 5A,A5,3C; address wraps to 00.
- Model never ACKs devsel, TIMEOUT_TICKS=8 → error=1 after 8 toggles in step 1; done pulse; eng_nreset=0; no further steps.
- cmd_len=0, then len=17, then write addr=0x0E len=3 → each gives error with done two cycles after cmd_start; eng_nreset never leaves 0.
- cmd_start and buf_wr_en asserted mid-read → both ignored, transaction unchanged. Assert nreset mid-step → all outputs at reset values within the same cycle; buffer = 0.
